// File: rtl/vga_pattern_source_if.sv
// -----------------------------------------------------------------------------
// vga_pattern_source_if
//   Bundles the VGA stream produced by vga_pattern_source together with the
//   pattern-select switches that steer it.
//
//   Signals:
//     SW           [2:0]  pattern select (driven by the consumer/board side)
//     oVGA_R/G/B   [7:0]  pixel colour, 0 outside the active area
//     oVGA_HS             horizontal sync, active low
//     oVGA_VS             vertical sync, active low
//     oVGA_SYNC_N         composite sync, tied low
//     oVGA_BLANK_N        high during the active image
//     frame_start         one-cycle pulse alongside pixel (0,0)
//
//   Modports:
//     master  the pattern source (reads SW, drives the video signals)
//     slave   the downstream consumer (drives SW, reads the video signals)
// -----------------------------------------------------------------------------
interface vga_pattern_source_if;
  logic [2:0] SW;
  logic [7:0] oVGA_R;
  logic [7:0] oVGA_G;
  logic [7:0] oVGA_B;
  logic       oVGA_HS;
  logic       oVGA_VS;
  logic       oVGA_SYNC_N;
  logic       oVGA_BLANK_N;
  logic       frame_start;

  modport master (
    input  SW,
    output oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS,
           oVGA_SYNC_N, oVGA_BLANK_N, frame_start
  );

  modport slave (
    output SW,
    input  oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS,
           oVGA_SYNC_N, oVGA_BLANK_N, frame_start
  );
endinterface

// File: rtl/vga_pattern_source.sv
// -----------------------------------------------------------------------------
// vga_pattern_source
//   Synthetic VGA transmitter. Generates HS/VS/BLANK_N/SYNC_N timing and 8-bit
//   RGB test images (colour bars, ramp, checkerboard, moving bar, impulse,
//   flat grey, black) that stand in for a camera feeding the filter pipeline.
//
//   Ports:
//     VGA_CLK  pixel clock, all logic on its rising edge
//     reset    synchronous, active-high reset
//     vga      vga_pattern_source_if.master: SW in, video signals out
//
//   Every output is registered: the values seen after edge n+1 describe the
//   counter position held during cycle n.
// -----------------------------------------------------------------------------
module vga_pattern_source #(
  parameter int WIDTH    = 800,
  parameter int HEIGHT   = 480,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int BAR_STEP = 4
) (
  input logic                  VGA_CLK,
  input logic                  reset,
  vga_pattern_source_if.master vga
);

  localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;

  // 12 bits covers the largest totals this block is used with and keeps the
  // ramp's x[9:2] slice always in range.
  localparam int CW = 12;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT    = cnt_t'(WIDTH);
  localparam cnt_t V_ACT    = cnt_t'(HEIGHT);
  localparam cnt_t HS_START = cnt_t'(WIDTH + H_FP);
  localparam cnt_t HS_END   = cnt_t'(WIDTH + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(HEIGHT + V_FP);
  localparam cnt_t VS_END   = cnt_t'(HEIGHT + V_FP + V_SYNC);
  localparam cnt_t BAR_W    = cnt_t'(WIDTH / 8);
  localparam cnt_t STEP     = cnt_t'(BAR_STEP);
  localparam cnt_t IMP_X    = cnt_t'(WIDTH / 2);
  localparam cnt_t IMP_Y    = cnt_t'(HEIGHT / 2);
  localparam cnt_t BAR_LEN  = cnt_t'(8);

  cnt_t        h_cnt_q, h_cnt_d;
  cnt_t        v_cnt_q, v_cnt_d;
  cnt_t        pos_q, pos_d;
  logic [2:0]  pat_q, pat_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        frame_start_q, frame_start_d;

  logic        line_wrap;
  logic        frame_wrap;
  logic        active;
  cnt_t        pos_sum;
  cnt_t        bar_idx;
  logic [23:0] pix;

  // Raster counters, pattern latch and bar position.
  always_comb begin
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    pat_d      = pat_q;
    pos_d      = pos_q;
    line_wrap  = (h_cnt_q == H_LAST);
    frame_wrap = line_wrap && (v_cnt_q == V_LAST);
    pos_sum    = pos_q + STEP;

    if (line_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
    end else begin
      h_cnt_d = h_cnt_q + cnt_t'(1);
    end

    // Pattern and bar only change between frames so an image never tears.
    if (frame_wrap) begin
      pat_d = vga.SW;
      pos_d = (pos_sum >= H_ACT) ? '0 : pos_sum;
    end
  end

  // Pixel colour for the current counter position.
  always_comb begin
    pix     = 24'h000000;
    active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    bar_idx = h_cnt_q / BAR_W;

    case (pat_q)
      3'd0: begin
        if (bar_idx < cnt_t'(8)) begin
          case (bar_idx[2:0])
            3'd0:    pix = 24'hFFFFFF;
            3'd1:    pix = 24'hFFFF00;
            3'd2:    pix = 24'h00FFFF;
            3'd3:    pix = 24'h00FF00;
            3'd4:    pix = 24'hFF00FF;
            3'd5:    pix = 24'hFF0000;
            3'd6:    pix = 24'h0000FF;
            default: pix = 24'h000000;
          endcase
        end
      end
      3'd1: pix = {3{h_cnt_q[9:2]}};
      3'd2: pix = (h_cnt_q[4] ^ v_cnt_q[4]) ? 24'hFFFFFF : 24'h000000;
      3'd3: pix = ((h_cnt_q >= pos_q) && (h_cnt_q < pos_q + BAR_LEN)) ?
                  24'hFFFFFF : 24'h000000;
      3'd4: pix = ((h_cnt_q == IMP_X) && (v_cnt_q == IMP_Y)) ?
                  24'hFFFFFF : 24'h000000;
      3'd5: pix = 24'h646464;
      default: pix = 24'h000000;
    endcase

    rgb_d         = active ? pix : 24'h000000;
    hs_d          = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    vs_d          = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    blank_n_d     = active;
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // State and output registers; SW is continuously captured while in reset.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pos_q         <= '0;
      pat_q         <= vga.SW;
      rgb_q         <= 24'h000000;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pos_q         <= pos_d;
      pat_q         <= pat_d;
      rgb_q         <= rgb_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.oVGA_R       = rgb_q[23:16];
  assign vga.oVGA_G       = rgb_q[15:8];
  assign vga.oVGA_B       = rgb_q[7:0];
  assign vga.oVGA_HS      = hs_q;
  assign vga.oVGA_VS      = vs_q;
  assign vga.oVGA_SYNC_N  = 1'b0;
  assign vga.oVGA_BLANK_N = blank_n_q;
  assign vga.frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_source.sv
// -----------------------------------------------------------------------------
// tb_vga_pattern_source
//   Self-checking bench for vga_pattern_source on a small 16x8 raster.
//   Expected video is derived from the elapsed cycle count since reset
//   release: pixel index, frame number, the switch value present on the last
//   edge of the previous frame and the bar rule give every output directly.
// -----------------------------------------------------------------------------
module tb_vga_pattern_source;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int HFP   = 2;
  localparam int HSYN  = 3;
  localparam int HBP   = 1;
  localparam int VFP   = 1;
  localparam int VSYN  = 2;
  localparam int VBP   = 1;
  localparam int STEP  = 4;
  localparam int HT    = W + HFP + HSYN + HBP;
  localparam int VT    = H + VFP + VSYN + VBP;
  localparam int FRAME = HT * VT;

  logic vga_clk = 1'b0;
  logic reset;

  vga_pattern_source_if bus ();

  vga_pattern_source #(
    .WIDTH(W), .HEIGHT(H), .H_FP(HFP), .H_SYNC(HSYN), .H_BP(HBP),
    .V_FP(VFP), .V_SYNC(VSYN), .V_BP(VBP), .BAR_STEP(STEP)
  ) dut (
    .VGA_CLK(vga_clk),
    .reset  (reset),
    .vga    (bus)
  );

  always #5 vga_clk = ~vga_clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  int         k_m;
  int         pat_m;
  int         pos_m;
  logic [2:0] sw_last;
  int         lit_cnt;
  int         vs_low_cnt;

  logic [23:0] bar_colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF,
                                  24'h00FF00, 24'hFF00FF, 24'hFF0000,
                                  24'h0000FF, 24'h000000};

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h",
               tag, $time, observed, expected);
    end
  endtask

  // Colour the spec assigns to pixel (x,y) for a given pattern and bar position.
  function automatic logic [23:0] model_rgb(input int x, input int y,
                                            input int pat, input int pos);
    logic [7:0] ramp;
    if (x >= W || y >= H) return 24'h0;
    case (pat)
      0: return (x / (W / 8) < 8) ? bar_colors[x / (W / 8)] : 24'h0;
      1: begin
        ramp = 8'((x / 4) % 256);
        return {ramp, ramp, ramp};
      end
      2: return ((((x / 16) % 2) ^ ((y / 16) % 2)) != 0) ? 24'hFFFFFF : 24'h0;
      3: return (x >= pos && x < pos + 8) ? 24'hFFFFFF : 24'h0;
      4: return (x == W / 2 && y == H / 2) ? 24'hFFFFFF : 24'h0;
      5: return 24'h646464;
      default: return 24'h0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model and compare all outputs.
  task automatic applyStimulus(input logic rst_in, input logic [2:0] sw_in);
    int p, x, y;
    logic [23:0] exp_rgb;
    logic [23:0] got_rgb;
    logic exp_hs, exp_vs, exp_blank, exp_fs;

    @(negedge vga_clk);
    reset  = rst_in;
    bus.SW = sw_in;
    @(posedge vga_clk);
    #1;
    got_rgb = {bus.oVGA_R, bus.oVGA_G, bus.oVGA_B};

    if (rst_in) begin
      k_m        = 0;
      pos_m      = 0;
      lit_cnt    = 0;
      vs_low_cnt = 0;
      exp_rgb    = 24'h0;
      exp_hs     = 1'b1;
      exp_vs     = 1'b1;
      exp_blank  = 1'b0;
      exp_fs     = 1'b0;
    end else begin
      p = k_m % FRAME;
      x = p % HT;
      y = p / HT;
      if (p == 0) begin
        if (k_m != 0) pos_m = (pos_m + STEP >= W) ? 0 : pos_m + STEP;
        pat_m      = int'(sw_last);
        lit_cnt    = 0;
        vs_low_cnt = 0;
      end
      exp_rgb   = model_rgb(x, y, pat_m, pos_m);
      exp_hs    = !(x >= W + HFP && x < W + HFP + HSYN);
      exp_vs    = !(y >= H + VFP && y < H + VFP + VSYN);
      exp_blank = (x < W) && (y < H);
      exp_fs    = (p == 0);
    end

    checkOutput(rst_in ? "rst_rgb" : "rgb", 32'(got_rgb), 32'(exp_rgb));
    checkOutput(rst_in ? "rst_hs" : "hs", 32'(bus.oVGA_HS), 32'(exp_hs));
    checkOutput(rst_in ? "rst_vs" : "vs", 32'(bus.oVGA_VS), 32'(exp_vs));
    checkOutput(rst_in ? "rst_blank_n" : "blank_n", 32'(bus.oVGA_BLANK_N),
                32'(exp_blank));
    checkOutput(rst_in ? "rst_frame_start" : "frame_start",
                32'(bus.frame_start), 32'(exp_fs));
    checkOutput("sync_n", 32'(bus.oVGA_SYNC_N), 32'(1'b0));

    if (!rst_in) begin
      if (got_rgb != 24'h0) lit_cnt++;
      if (!bus.oVGA_VS) vs_low_cnt++;
      if (p == FRAME - 1) begin
        checkOutput("vs_low_cycles", 32'(vs_low_cnt), 32'(VSYN * HT));
        if (pat_m == 4) checkOutput("impulse_count", 32'(lit_cnt), 32'd1);
      end
      k_m++;
    end
    sw_last = sw_in;
  endtask

  // Run n cycles out of reset with a fixed switch setting.
  task automatic run_cycles(input int n, input logic [2:0] sw_in);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, sw_in);
  endtask

  initial begin
    logic [2:0] sw_rand;
    reset      = 1'b1;
    bus.SW     = 3'd0;
    sw_last    = 3'd0;
    k_m        = 0;
    pat_m      = 0;
    pos_m      = 0;
    lit_cnt    = 0;
    vs_low_cnt = 0;

    // Reset held for three cycles with an arbitrary switch value.
    sw_rand = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, sw_rand);

    // Colour bars, impulse, then a moving bar over several frames.
    run_cycles(2 * FRAME, 3'd0);
    run_cycles(2 * FRAME, 3'd4);
    run_cycles(6 * FRAME, 3'd3);

    // Flat grey with a mid-frame switch to the checkerboard.
    run_cycles(FRAME + FRAME / 2, 3'd5);
    run_cycles(FRAME / 2 + FRAME, 3'd2);

    // Random switch activity, including the ramp and black patterns.
    sw_rand = 3'($urandom_range(0, 7));
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ($urandom_range(0, 99) == 0) sw_rand = 3'($urandom_range(0, 7));
      applyStimulus(1'b0, sw_rand);
    end
    run_cycles(2 * FRAME, 3'd1);

    // Reset asserted part-way through a frame, then a clean restart.
    run_cycles(int'($urandom_range(20, FRAME - 20)), 3'd3);
    sw_rand = 3'($urandom_range(0, 7));
    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
      applyStimulus(1'b1, sw_rand);
    run_cycles(3 * FRAME, 3'($urandom_range(0, 7)));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
